// File: rtl/cmem_spi_arbiter.sv
// cmem_spi_arbiter: two-requester round-robin arbiter for the SPI-side nibble
// port of the communication memory.
// Requester A (SPI command engine) and B (housekeeping/debug reader) each
// present a held command (req/we/addr/wdata). At most one command is issued per
// cycle as registered spi_read/spi_write strobes. Read nibbles return three
// cycles after the grant decision on rdata_x/rvalid_x of the issuing requester.
// Optional feature macro: CMEM_ARB_LOCK_EN (lock_x ownership with MAX_LOCK cap).
// Ports:
//   i_clk200, i_reset_n            clock, synchronous active-low reset
//   i_req_x, i_we_x, i_addr_x,
//   i_wdata_x, i_lock_x            requester command fields (x = a, b)
//   o_ack_x                        command issued this cycle
//   o_rvalid_x, o_rdata_x          read return, rdata held until next rvalid
//   o_lock_lost_x                  lock force-released after MAX_LOCK grants
//   o_spi_read, o_spi_write,
//   o_spi_address, o_spi_out_cmem_in   registered cmem command
//   i_spi_in_cmem_out              cmem read data, valid cycle after spi_read
module cmem_spi_arbiter #(
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic       i_clk200,
    input  logic       i_reset_n,
    input  logic       i_req_a,
    input  logic       i_req_b,
    input  logic       i_we_a,
    input  logic       i_we_b,
    input  logic [3:0] i_addr_a,
    input  logic [3:0] i_addr_b,
    input  logic [3:0] i_wdata_a,
    input  logic [3:0] i_wdata_b,
    input  logic       i_lock_a,
    input  logic       i_lock_b,
    output logic       o_ack_a,
    output logic       o_ack_b,
    output logic       o_rvalid_a,
    output logic       o_rvalid_b,
    output logic [3:0] o_rdata_a,
    output logic [3:0] o_rdata_b,
    output logic       o_lock_lost_a,
    output logic       o_lock_lost_b,
    output logic       o_spi_read,
    output logic       o_spi_write,
    output logic [3:0] o_spi_address,
    output logic [3:0] o_spi_out_cmem_in,
    input  logic [3:0] i_spi_in_cmem_out
);

    localparam int unsigned NIB_W      = 4;
    localparam logic [3:0]  LP_MAX_CNT = 4'(MAX_LOCK);

    logic             r_ack_a, r_ack_b;
    logic             r_spi_read, r_spi_write;
    logic [NIB_W-1:0] r_spi_address, r_spi_wdata;
    logic             r_ptr_b;
    logic             r_tag0_vld, r_tag0_b, r_tag1_vld, r_tag1_b;
    logic             r_rvalid_a, r_rvalid_b;
    logic [NIB_W-1:0] r_rdata_a, r_rdata_b;

    logic             w_own_a, w_own_b;
    logic             w_lk_grant;
    logic             w_lost_a, w_lost_b;
    logic             w_elig_a, w_elig_b;
    logic             w_grant_a, w_grant_b, w_grant;
    logic             w_we;
    logic [NIB_W-1:0] w_addr, w_wdata;

    // Grant decision: held commands are masked during their ack cycle; an
    // active lock owner makes the other requester ineligible.
    always_comb begin
        w_elig_a  = i_req_a && !r_ack_a && !w_own_b;
        w_elig_b  = i_req_b && !r_ack_b && !w_own_a;
        w_grant_a = w_elig_a && (!w_elig_b || !r_ptr_b);
        w_grant_b = w_elig_b && (!w_elig_a ||  r_ptr_b);
        w_grant   = w_grant_a || w_grant_b;
        w_we      = w_grant_b ? i_we_b    : i_we_a;
        w_addr    = w_grant_b ? i_addr_b  : i_addr_a;
        w_wdata   = w_grant_b ? i_wdata_b : i_wdata_a;
    end

    // Command issue, round-robin pointer and 2-stage read-owner tag pipeline.
    always_ff @(posedge i_clk200) begin
        if (!i_reset_n) begin
            r_ack_a       <= 1'b0;
            r_ack_b       <= 1'b0;
            r_spi_read    <= 1'b0;
            r_spi_write   <= 1'b0;
            r_spi_address <= '0;
            r_spi_wdata   <= '0;
            r_ptr_b       <= 1'b0;
            r_tag0_vld    <= 1'b0;
            r_tag0_b      <= 1'b0;
            r_tag1_vld    <= 1'b0;
            r_tag1_b      <= 1'b0;
            r_rvalid_a    <= 1'b0;
            r_rvalid_b    <= 1'b0;
            r_rdata_a     <= '0;
            r_rdata_b     <= '0;
        end else begin
            r_ack_a     <= w_grant_a;
            r_ack_b     <= w_grant_b;
            r_spi_read  <= w_grant && !w_we;
            r_spi_write <= w_grant &&  w_we;
            if (w_grant) begin
                r_spi_address <= w_addr;
                r_spi_wdata   <= w_wdata;
            end
            // Pointer favours the requester not served last; frozen under lock.
            if (w_grant && !w_lk_grant) begin
                r_ptr_b <= w_grant_a;
            end
            r_tag0_vld <= w_grant && !w_we;
            r_tag0_b   <= w_grant_b;
            r_tag1_vld <= r_tag0_vld;
            r_tag1_b   <= r_tag0_b;
            r_rvalid_a <= r_tag1_vld && !r_tag1_b;
            r_rvalid_b <= r_tag1_vld &&  r_tag1_b;
            if (r_tag1_vld && !r_tag1_b) begin
                r_rdata_a <= i_spi_in_cmem_out;
            end
            if (r_tag1_vld && r_tag1_b) begin
                r_rdata_b <= i_spi_in_cmem_out;
            end
        end
    end

`ifdef CMEM_ARB_LOCK_EN
    logic       r_own_a, r_own_b;
    logic       r_blk_a, r_blk_b;
    logic       r_pend_a, r_pend_b;
    logic       r_lost_a, r_lost_b;
    logic [3:0] r_cnt;
    logic       w_lk_a, w_lk_b;
    logic [3:0] w_cnt_inc;
    logic       w_force;

    // Ownership drops combinationally as soon as lock_x is sampled low, so
    // the other requester can be granted on that same edge.
    always_comb begin
        w_own_a    = r_own_a && i_lock_a;
        w_own_b    = r_own_b && i_lock_b;
        w_lk_a     = w_grant_a && i_lock_a && !r_blk_a;
        w_lk_b     = w_grant_b && i_lock_b && !r_blk_b;
        w_lk_grant = w_lk_a || w_lk_b;
        w_cnt_inc  = 4'd1;
        if ((w_lk_a && r_own_a) || (w_lk_b && r_own_b)) begin
            w_cnt_inc = r_cnt + 4'd1;
        end
        w_force    = w_lk_grant && (w_cnt_inc == LP_MAX_CNT);
        w_lost_a   = r_lost_a;
        w_lost_b   = r_lost_b;
    end

    // Lock owner, shared grant count, forced release and re-lock block.
    always_ff @(posedge i_clk200) begin
        if (!i_reset_n) begin
            r_own_a  <= 1'b0;
            r_own_b  <= 1'b0;
            r_blk_a  <= 1'b0;
            r_blk_b  <= 1'b0;
            r_pend_a <= 1'b0;
            r_pend_b <= 1'b0;
            r_lost_a <= 1'b0;
            r_lost_b <= 1'b0;
            r_cnt    <= 4'd0;
        end else begin
            // Pend stage puts lost one cycle after the final ack.
            r_pend_a <= w_lk_a && w_force;
            r_pend_b <= w_lk_b && w_force;
            r_lost_a <= r_pend_a;
            r_lost_b <= r_pend_b;

            if (!i_lock_a) begin
                r_blk_a <= 1'b0;
            end else if (w_lk_a && w_force) begin
                r_blk_a <= 1'b1;
            end
            if (!i_lock_b) begin
                r_blk_b <= 1'b0;
            end else if (w_lk_b && w_force) begin
                r_blk_b <= 1'b1;
            end

            if (w_lk_a) begin
                r_own_a <= !w_force;
            end else if (!i_lock_a) begin
                r_own_a <= 1'b0;
            end
            if (w_lk_b) begin
                r_own_b <= !w_force;
            end else if (!i_lock_b) begin
                r_own_b <= 1'b0;
            end

            if (w_lk_grant) begin
                r_cnt <= w_force ? 4'd0 : w_cnt_inc;
            end else if ((r_own_a && !i_lock_a) || (r_own_b && !i_lock_b)) begin
                r_cnt <= 4'd0;
            end
        end
    end
`else
    logic w_unused_lock;

    assign w_own_a       = 1'b0;
    assign w_own_b       = 1'b0;
    assign w_lk_grant    = 1'b0;
    assign w_lost_a      = 1'b0;
    assign w_lost_b      = 1'b0;
    assign w_unused_lock = &{1'b0, i_lock_a, i_lock_b, LP_MAX_CNT};
`endif

    assign o_ack_a           = r_ack_a;
    assign o_ack_b           = r_ack_b;
    assign o_rvalid_a        = r_rvalid_a;
    assign o_rvalid_b        = r_rvalid_b;
    assign o_rdata_a         = r_rdata_a;
    assign o_rdata_b         = r_rdata_b;
    assign o_lock_lost_a     = w_lost_a;
    assign o_lock_lost_b     = w_lost_b;
    assign o_spi_read        = r_spi_read;
    assign o_spi_write       = r_spi_write;
    assign o_spi_address     = r_spi_address;
    assign o_spi_out_cmem_in = r_spi_wdata;

endmodule

// File: tb/tb_cmem_spi_arbiter.sv
// Self-checking bench for cmem_spi_arbiter with a behavioural cmem and a
// per-requester scoreboard of expected commands and read nibbles.
module tb_cmem_spi_arbiter;

    localparam int unsigned MAX_LOCK = 8;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [3:0] wd;
    } cmd_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_a, req_b, we_a, we_b, lock_a, lock_b;
    logic [3:0] addr_a, addr_b, wdata_a, wdata_b;
    logic       ack_a, ack_b, rvalid_a, rvalid_b, lost_a, lost_b;
    logic [3:0] rdata_a, rdata_b;
    logic       spi_read, spi_write;
    logic [3:0] spi_address, spi_out, cmem_q;

    // Memory content i ^ 9; addr 0xC holds 0x5.
    logic [3:0] mem    [16] = '{4'h9, 4'h8, 4'hB, 4'hA, 4'hD, 4'hC, 4'hF, 4'hE,
                                4'h1, 4'h0, 4'h3, 4'h2, 4'h5, 4'h4, 4'h7, 4'h6};
    logic [3:0] shadow [16] = '{4'h9, 4'h8, 4'hB, 4'hA, 4'hD, 4'hC, 4'hF, 4'hE,
                                4'h1, 4'h0, 4'h3, 4'h2, 4'h5, 4'h4, 4'h7, 4'h6};

    cmd_t       exp_cmd_a[$], exp_cmd_b[$];
    logic [3:0] exp_rd_a[$], exp_rd_b[$];
    int         log_cyc[$];
    bit         log_side[$];
    int         lost_a_cyc[$];
    int         n_lost_b = 0;
    int         last_rv_a_cyc = -1;
    int         cyc = 0;
    int         n_err = 0;
    int         n_checks = 0;

    always #5 clk = ~clk;

    cmem_spi_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .i_clk200         (clk),
        .i_reset_n        (reset_n),
        .i_req_a          (req_a),
        .i_req_b          (req_b),
        .i_we_a           (we_a),
        .i_we_b           (we_b),
        .i_addr_a         (addr_a),
        .i_addr_b         (addr_b),
        .i_wdata_a        (wdata_a),
        .i_wdata_b        (wdata_b),
        .i_lock_a         (lock_a),
        .i_lock_b         (lock_b),
        .o_ack_a          (ack_a),
        .o_ack_b          (ack_b),
        .o_rvalid_a       (rvalid_a),
        .o_rvalid_b       (rvalid_b),
        .o_rdata_a        (rdata_a),
        .o_rdata_b        (rdata_b),
        .o_lock_lost_a    (lost_a),
        .o_lock_lost_b    (lost_b),
        .o_spi_read       (spi_read),
        .o_spi_write      (spi_write),
        .o_spi_address    (spi_address),
        .o_spi_out_cmem_in(spi_out),
        .i_spi_in_cmem_out(cmem_q)
    );

    // cmem: writes in the strobe cycle, read data registered one cycle later.
    always @(posedge clk) begin
        if (spi_write) mem[spi_address] <= spi_out;
        if (spi_read)  cmem_q <= mem[spi_address];
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: route each strobe by its ack and match rvalids to scoreboard.
    always @(negedge clk) begin
        cmd_t c;
        if (spi_read || spi_write) begin
            chk("one_ack_per_strobe", 32'(ack_a) + 32'(ack_b), 32'd1);
            if (ack_a) begin
                chk("strobe_expected_a", 32'(exp_cmd_a.size() != 0), 32'd1);
                if (exp_cmd_a.size() != 0) begin
                    c = exp_cmd_a.pop_front();
                    chk("strobe_a", 32'({spi_read, spi_write, spi_address, spi_write ? spi_out : 4'h0}),
                        32'({!c.we, c.we, c.addr, c.we ? c.wd : 4'h0}));
                end
                log_cyc.push_back(cyc);
                log_side.push_back(1'b0);
            end
            if (ack_b) begin
                chk("strobe_expected_b", 32'(exp_cmd_b.size() != 0), 32'd1);
                if (exp_cmd_b.size() != 0) begin
                    c = exp_cmd_b.pop_front();
                    chk("strobe_b", 32'({spi_read, spi_write, spi_address, spi_write ? spi_out : 4'h0}),
                        32'({!c.we, c.we, c.addr, c.we ? c.wd : 4'h0}));
                end
                log_cyc.push_back(cyc);
                log_side.push_back(1'b1);
            end
        end else if (ack_a || ack_b) begin
            chk("ack_without_strobe", 32'({ack_a, ack_b}), 32'd0);
        end
        if (rvalid_a) begin
            last_rv_a_cyc = cyc;
            chk("rvalid_expected_a", 32'(exp_rd_a.size() != 0), 32'd1);
            if (exp_rd_a.size() != 0) chk("rdata_a", 32'(rdata_a), 32'(exp_rd_a.pop_front()));
        end
        if (rvalid_b) begin
            chk("rvalid_expected_b", 32'(exp_rd_b.size() != 0), 32'd1);
            if (exp_rd_b.size() != 0) chk("rdata_b", 32'(rdata_b), 32'(exp_rd_b.pop_front()));
        end
        if (lost_a) lost_a_cyc.push_back(cyc);
        if (lost_b) n_lost_b++;
    end

    // Present one command, push its expectations, wait (bounded) for its ack.
    task automatic issue(input bit side, input bit we, input logic [3:0] addr,
                         input logic [3:0] wd, input bit expect_rd,
                         input int hold_extra, output int ack_cyc);
        cmd_t c;
        logic got;
        c = '{we: we, addr: addr, wd: wd};
        if (!side) exp_cmd_a.push_back(c); else exp_cmd_b.push_back(c);
        if (we) shadow[addr] = wd;
        else if (expect_rd) begin
            if (!side) exp_rd_a.push_back(shadow[addr]); else exp_rd_b.push_back(shadow[addr]);
        end
        if (!side) begin we_a = we; addr_a = addr; wdata_a = wd; req_a = 1'b1; end
        else       begin we_b = we; addr_b = addr; wdata_b = wd; req_b = 1'b1; end
        ack_cyc = -1;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            got = side ? ack_b : ack_a;
            if (got) begin ack_cyc = cyc; break; end
        end
        if (!got) chk(side ? "ack_timeout_b" : "ack_timeout_a", 32'(got), 32'd1);
        repeat (hold_extra) begin @(posedge clk); #1; end
        if (!side) req_a = 1'b0; else req_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_a = 0; req_b = 0; we_a = 0; we_b = 0; lock_a = 0; lock_b = 0;
        addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
        idle(3);
        reset_n = 1'b1;
        log_cyc.delete();
        log_side.delete();
        lost_a_cyc.delete();
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({ack_a, ack_b, rvalid_a, rvalid_b, rdata_a, rdata_b, lost_a, lost_b,
                    spi_read, spi_write, spi_address, spi_out});
    endfunction

    task automatic check_order(input string tag, input int n, input bit exp_side[$]);
        chk({tag, "_count"}, log_cyc.size(), n);
        for (int i = 0; i < n && i < log_cyc.size() && i < exp_side.size(); i++)
            chk({tag, "_side"}, 32'(log_side[i]), 32'(exp_side[i]));
    endtask

    initial begin
        int c0, ac0, ac1, a_done;
        bit abab[$];
        abab = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Reset values
        do_reset();
        chk("reset_outputs", all_outs(), 32'd0);

        // Single read: A reads 0xC, held through the ack cycle.
        c0 = cyc;
        issue(1'b0, 1'b0, 4'hC, 4'h0, 1'b1, 1, ac0);
        chk("single_ack_cycle", ac0, c0 + 1);
        idle(4);
        chk("single_rvalid_cycle", last_rv_a_cyc, c0 + 3);
        chk("single_strobe_count", log_cyc.size(), 1);

        // Contention from reset: A, B, A, B on consecutive cycles.
        do_reset();
        fork
            begin issue(1'b0, 1'b0, 4'h1, 4'h0, 1'b1, 0, ac0); issue(1'b0, 1'b0, 4'h3, 4'h0, 1'b1, 0, ac0); end
            begin issue(1'b1, 1'b0, 4'h2, 4'h0, 1'b1, 0, ac1); issue(1'b1, 1'b0, 4'h4, 4'h0, 1'b1, 0, ac1); end
        join
        idle(5);
        check_order("contention", 4, abab);
        if (log_cyc.size() == 4) chk("contention_back_to_back", log_cyc[3] - log_cyc[0], 3);

        // Write then read: B writes 0x9 to 0xB then reads it back.
        do_reset();
        issue(1'b1, 1'b1, 4'hB, 4'h9, 1'b0, 0, ac1);
        issue(1'b1, 1'b0, 4'hB, 4'h0, 1'b1, 0, ac1);
        idle(5);
        chk("wr_rd_drain_b", exp_rd_b.size(), 0);

`ifdef CMEM_ARB_LOCK_EN
        // Lock: six locked A reads starve B until lock_a drops.
        do_reset();
        a_done = 0;
        fork
            begin
                lock_a = 1'b1;
                for (int i = 0; i < 6; i++) issue(1'b0, 1'b0, 4'(i), 4'h0, 1'b1, 0, ac0);
                lock_a = 1'b0;
                a_done = cyc;
            end
            begin
                for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 4'hE, 4'h0, 1'b1, 0, ac1);
            end
        join
        idle(5);
        chk("lock_count", log_cyc.size(), 9);
        for (int i = 0; i < 6 && i < log_side.size(); i++) chk("lock_a_only", 32'(log_side[i]), 32'd0);
        if (log_cyc.size() > 6) begin
            chk("lock_b_after_side", 32'(log_side[6]), 32'd1);
            chk("lock_b_after_cycle", log_cyc[6], a_done + 1);
        end
        chk("lock_no_lost", lost_a_cyc.size(), 0);

        // Overrun: ten reads with lock_a held; forced release after the 8th.
        do_reset();
        fork
            begin
                lock_a = 1'b1;
                for (int i = 0; i < 10; i++) issue(1'b0, 1'b0, 4'(i), 4'h0, 1'b1, 0, ac0);
                lock_a = 1'b0;
            end
            begin issue(1'b1, 1'b0, 4'hF, 4'h0, 1'b1, 0, ac1); end
        join
        idle(5);
        chk("overrun_count", log_cyc.size(), 11);
        for (int i = 0; i < 8 && i < log_side.size(); i++) chk("overrun_a_first", 32'(log_side[i]), 32'd0);
        chk("overrun_lost_pulses", lost_a_cyc.size(), 1);
        if (log_cyc.size() > 8) begin
            chk("overrun_b_next", 32'(log_side[8]), 32'd1);
            chk("overrun_b_cycle", log_cyc[8], log_cyc[7] + 1);
            if (lost_a_cyc.size() > 0) chk("overrun_lost_cycle", lost_a_cyc[0], log_cyc[7] + 1);
        end
        chk("overrun_lost_b", n_lost_b, 0);
`else
        // Lock inputs have no effect: plain alternation, no lock_lost.
        do_reset();
        lock_a = 1'b1;
        lock_b = 1'b1;
        fork
            begin issue(1'b0, 1'b0, 4'h5, 4'h0, 1'b1, 0, ac0); issue(1'b0, 1'b0, 4'h6, 4'h0, 1'b1, 0, ac0); end
            begin issue(1'b1, 1'b0, 4'h7, 4'h0, 1'b1, 0, ac1); issue(1'b1, 1'b0, 4'h8, 4'h0, 1'b1, 0, ac1); end
        join
        lock_a = 1'b0;
        lock_b = 1'b0;
        idle(5);
        check_order("lock_ignored", 4, abab);
        chk("lock_ignored_lost", lost_a_cyc.size() + n_lost_b, 0);
`endif

        // Reset during N+2 of an A read: its rvalid must never appear.
        do_reset();
        c0 = cyc;
        issue(1'b0, 1'b0, 4'h7, 4'h0, 1'b0, 0, ac0);
        chk("midreset_ack_cycle", ac0, c0 + 1);
        idle(1);
        reset_n = 1'b0;
        idle(1);
        chk("midreset_outputs", all_outs(), 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(5);
        chk("post_reset_outputs", all_outs(), 32'd0);

        chk("drain_cmd_a", exp_cmd_a.size(), 0);
        chk("drain_cmd_b", exp_cmd_b.size(), 0);
        chk("drain_rd_a", exp_rd_a.size(), 0);
        chk("drain_rd_b", exp_rd_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (errors=%0d)", n_err);
        $fatal(1);
    end

endmodule

// File: doc/cmem_spi_arbiter.md
# cmem_spi_arbiter

Shares the SPI-side nibble port of the communication memory between two requesters: A, the SPI command engine, and B, the on-FPGA housekeeping/debug reader. It issues at most one registered read or write strobe per cycle, alternates grants round-robin, and routes each read nibble back to the requester that issued it. An optional lock lets one requester keep the port across a multi-nibble sequence, such as reading BA0-5 as one consistent base address.

## Interface
- MAX_LOCK, default 8: maximum number of consecutive locked grants before a lock is forcibly released (1..15).
- clk200  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_a / req_b  in  1  access request; command fields held stable until ack
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  4  cmem nibble address
- wdata_a / wdata_b  in  4  write nibble
- lock_a / lock_b  in  1  request exclusive ownership (CMEM_ARB_LOCK_EN only)
- ack_a / ack_b  out  1  one-cycle pulse: command issued to cmem this cycle
- rvalid_a / rvalid_b  out  1  one-cycle pulse: rdata valid
- rdata_a / rdata_b  out  4  read nibble, held until next rvalid
- lock_lost_a / lock_lost_b  out  1  one-cycle pulse: lock force-released by MAX_LOCK
- spi_read / spi_write  out  1  registered strobes to cmem
- spi_address  out  4  registered cmem address
- spi_out_cmem_in  out  4  registered write nibble
- spi_in_cmem_out  in  4  cmem read data, valid the cycle after spi_read

## Operation
- Eligible(x) = req_x && !ack_x. This masks the requester acked in the current cycle and prevents a double issue of a held command.
- Grant decision each cycle among the eligible requesters:
  - One eligible requester: it wins.
  - Both eligible: the requester not granted last wins. The round-robin pointer resets to favour A.
  - None eligible: no strobe next cycle.
- On grant, next cycle:
  - spi_address and spi_out_cmem_in take the winner's addr and wdata.
  - spi_read = !we, spi_write = we.
  - ack of the winner = 1.
  - The pointer records the winner.
- Strobe-free cycles: spi_read = spi_write = 0; address and data hold their last values.
- Read return: a 2-stage tag pipeline tracks the read owner. rdata_x is registered from spi_in_cmem_out and rvalid_x pulses. Writes produce no rvalid.
- Read and write ordering per requester is preserved. A read following a write to the same address returns the new value, because cmem writes in the strobe cycle.
- Reset mid-operation: the tag pipeline is cleared. No rvalid or ack is emitted for commands in flight. The pointer returns to A.

## Timing
- Reset values: all strobes, acks, rvalids and lock_lost are 0; spi_address, spi_out_cmem_in and rdata_x are 0; no lock is held.
- req first sampled at edge N → strobe and ack high during cycle N+1 → cmem output valid N+2 → rvalid high during N+3.
- Single requester throughput: one access per 2 cycles. Two requesters alternating: one access per cycle.
- Requester rule: change the command fields or drop req only after seeing ack. Dropping req before ack cancels the request and is legal.

## Configuration
- CMEM_ARB_LOCK_EN defined:
  - Taking a lock: a grant to x with lock_x = 1 makes x owner. While owned, the other requester is ineligible.
  - Lock count: each locked grant increments a 4-bit count.
  - Normal release: release on any cycle where lock_x is sampled low.
  - Forced release: release after MAX_LOCK locked grants, with a lock_lost_x pulse in the cycle after the MAX_LOCK-th ack. x cannot re-lock until it samples lock_x low once.
  - Pointer: while a lock is held, the round-robin pointer does not advance.
- CMEM_ARB_LOCK_EN undefined: lock inputs are ignored, lock_lost outputs are tied 0, and there is no lock logic.

## Test plan
- Single read: A reads addr 0xC while cmem holds 0x5.
  - spi_read=1, spi_address=0xC, ack_a in cycle N+1.
  - rvalid_a=1 and rdata_a=0x5 in N+3.
  - No second strobe while req_a is held through the ack.
- Contention: A and B both request reads from reset.
  - Strobes ordered A, B, A, B on consecutive cycles.
  - Each rvalid carries the nibble for its own address.
- Write then read: B writes 0x9 to addr 0xB, then reads 0xB.
  - spi_write with spi_out_cmem_in=0x9.
  - rdata_b=0x9.
- Lock, with CMEM_ARB_LOCK_EN defined: A holds lock_a=1 and reads addrs 0..5 while B requests continuously.
  - Six A strobes, no B strobe.
  - B is granted in the cycle after lock_a drops.
- Lock overrun, MAX_LOCK=8: A keeps lock_a=1 for 10 reads.
  - lock_lost_a pulses after the 8th ack.
  - B is granted next.
- Reset mid-read: reset_n low in N+2 after an A read strobe.
  - No rvalid_a.
  - All outputs read 0 after reset.
